led_uart_tx: RTL and testbench
==============================

Name: led_uart_tx

Overview:
- Sits directly downstream of the processor core and consumes its 32-bit `led` result bus.
- Captures each new value that differs from the previously captured one and buffers it in a small FIFO.
- Serialises each buffered word over a UART TX line as 8 uppercase hex ASCII characters followed by CR LF.
- Gives the bench and the board a cycle-independent trace of the core's write-back results.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit; legal range ≥2.
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW words.

Ports:
- clk  input  1  system clock; all state updates on the posedge.
- rst  input  1  asynchronous reset, active-low.
- value  input  32  result bus from the processor core (its `led`).
- txd  output  1  UART serial out; idle high.
- busy  output  1  high while a frame is in flight or the FIFO is non-empty.
- ovf_cnt  output  8  count of dropped captures; saturates at 255.

Behaviour:
- Reset: rst low asynchronously forces txd=1, busy=0, ovf_cnt=0, FIFO empty, last-captured register=0, FSM=IDLE, char_idx=0, bit counter=0, baud counter=0.
- Capture stage:
  - value is registered every cycle into v_q.
  - Change condition: v_q != last.
  - On a change, push v_q and update last in the same cycle.
  - A change is therefore pushed 2 edges after value changes.
  - The first nonzero value after reset counts as a change; 0 after reset does not.
- FIFO:
  - Depth 2**FIFO_AW; pointers FIFO_AW+1 bits wide, wrap naturally.
  - full = MSBs differ and lower bits equal; empty = pointers equal.
  - Push while full with no pop that cycle: drop the word, keep last updated to v_q, ovf_cnt += 1 (saturating).
  - Push and pop in the same cycle while full: accepted, no drop.
- FSM states: IDLE, LOAD, START, DATA, PAR, STOP.
  - IDLE: if the FIFO is non-empty, pop into word_r, char_idx=0, go to LOAD.
  - LOAD (1 cycle): form char from char_idx.
    - char_idx 0..7 selects nibble word_r[31-4k -: 4]; 0..9 maps to 0x30+n, A..F maps to 0x41+(n-10).
    - char_idx 8 = 0x0D; char_idx 9 = 0x0A.
    - Then go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles, then PAR (feature on) or STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. If char_idx==9, go to IDLE; else char_idx+=1 and go to LOAD.
- Timing and flow:
  - The baud counter reloads at every state entry and counts down to 0.
  - Frames are back-to-back within a word except for the 1 LOAD cycle.
  - No handshake toward the core: capture never stalls; loss is visible only via ovf_cnt.
- Outputs:
  - txd is registered (glitch-free).
  - busy = (FSM != IDLE) | !empty, registered.
- Reset mid-frame aborts immediately: the partial character is lost and txd returns high asynchronously.
- Latency: value change at edge N → push at N+2 → pop at N+3 → LOAD at N+4 → txd falls at edge N+5 (FIFO empty, FSM idle).

Optional Feature:
- Macro: LED_UART_PARITY_EN.
- Defined: PAR state inserted after DATA; txd = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11 bits.
- Undefined: PAR state is absent from the encoding, DATA goes straight to STOP. Frame = 10 bits (8N1).

Test Plan:
- CLKS_PER_BIT=4, value 0→0x000000A5 held.
  - Required: exactly one word of bytes 30 30 30 30 30 30 41 35 0D 0A on txd, 8N1.
  - Each bit 4 cycles; txd falls 5 edges after the change.
  - busy stays high until the last stop bit ends.
- Value held constant at 0 for 2000 cycles after reset → txd stays 1, busy=0, ovf_cnt=0.
- FIFO_AW=3, 12 distinct values on consecutive cycles (0x1..0xC) while idle.
  - Required: 0x1 is popped immediately; 0x2..0x9 are buffered (8); 0xA..0xC are dropped; ovf_cnt=3.
  - Decoded output sequence: 00000001 … 00000009.
- FIFO full, and a new value arrives in the same cycle as the IDLE pop → word accepted, ovf_cnt unchanged.
- rst pulsed low in the middle of DATA of char 3.
  - Required: txd=1 asynchronously, busy=0, ovf_cnt=0.
  - After release, value 0xDEADBEEF yields 44 45 41 44 42 45 45 46 0D 0A.
- LED_UART_PARITY_EN defined, value 0x00000007 ('7'=0x37, five ones) → the parity bit of that frame is 1; the '0' frames (0x30, two ones) carry parity bit 0; frame length is 44 cycles.

Source files
------------

// File: rtl/led_uart_tx.sv
// led_uart_tx
//   Watches the core's 32-bit result bus and captures every value that differs
//   from the previously captured one into a small FIFO. Each buffered word is
//   sent on a UART line as 8 uppercase hex ASCII characters followed by CR LF.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (>= 2)
//   FIFO_AW      : FIFO address width, depth = 2**FIFO_AW words
//
// Ports
//   clk     : system clock, all state changes on the rising edge
//   rst     : asynchronous reset, active-low
//   value   : result bus from the processor core
//   txd     : UART serial output, idle high, registered
//   busy    : a frame is in flight or the FIFO holds data, registered
//   ovf_cnt : number of captures dropped on a full FIFO, saturates at 255
//
// Build option
//   LED_UART_PARITY_EN : when defined, an even-parity bit follows the data
//                        bits (8E1, 11-bit frame); otherwise frames are 8N1.
module led_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_AW      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    output logic        txd,
    output logic        busy,
    output logic [7:0]  ovf_cnt
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned PW    = FIFO_AW + 1;
    localparam int unsigned CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);

`ifdef LED_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PAR, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
`endif

    // Capture and FIFO
    logic [31:0]   r_vq;
    logic [31:0]   r_last;
    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [7:0]    r_ovf;

    // Serialiser
    state_t        r_state;
    logic [31:0]   r_word;
    logic [3:0]    r_char_idx;
    logic [7:0]    r_char;
    logic [2:0]    r_bit_idx;
    logic [CW-1:0] r_baud;
    logic          r_txd;
    logic          r_busy;

    logic          w_empty;
    logic          w_full;
    logic          w_change;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [4:0]    w_nib_base;
    logic [3:0]    w_nib;
    logic [7:0]    w_char;

    always_comb begin
        w_empty  = (r_wr_ptr == r_rd_ptr);
        w_full   = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                   (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
        w_change = (r_vq != r_last);
        w_pop    = (r_state == IDLE) && !w_empty;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        w_push   = w_change && (!w_full || w_pop);
        w_drop   = w_change && w_full && !w_pop;
    end

    // Character selection: nibbles MSB first, then CR, LF.
    always_comb begin
        w_nib_base = 5'd28 - {r_char_idx[2:0], 2'b00};
        w_nib      = r_word[w_nib_base +: 4];
        if (r_char_idx == 4'd8) begin
            w_char = 8'h0D;
        end else if (r_char_idx == 4'd9) begin
            w_char = 8'h0A;
        end else if (w_nib < 4'd10) begin
            w_char = 8'h30 + {4'h0, w_nib};
        end else begin
            w_char = 8'h37 + {4'h0, w_nib};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vq     <= '0;
            r_last   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= '0;
        end else begin
            r_vq <= value;
            // last follows v_q even when the word is dropped
            if (w_change) r_last <= r_vq;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_drop && (r_ovf != 8'hFF)) r_ovf <= r_ovf + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= r_vq;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_char_idx <= '0;
            r_char     <= '0;
            r_bit_idx  <= '0;
            r_baud     <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_busy <= (r_state != IDLE) || !w_empty;

            // txd is decoded from the state held during the previous cycle,
            // so the line lags the FSM by exactly one clock.
            unique case (r_state)
                START:   r_txd <= 1'b0;
                DATA:    r_txd <= r_char[r_bit_idx];
`ifdef LED_UART_PARITY_EN
                PAR:     r_txd <= ^r_char;
`endif
                default: r_txd <= 1'b1;
            endcase

            unique case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_word     <= r_mem[r_rd_ptr[FIFO_AW-1:0]];
                        r_char_idx <= '0;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    r_char  <= w_char;
                    r_baud  <= BAUD_RELOAD;
                    r_state <= START;
                end
                START: begin
                    if (r_baud == '0) begin
                        r_baud    <= BAUD_RELOAD;
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end else begin
                        r_baud <= r_baud - CW'(1);
                    end
                end
                DATA: begin
                    if (r_baud == '0) begin
                        r_baud <= BAUD_RELOAD;
                        if (r_bit_idx == 3'd7) begin
`ifdef LED_UART_PARITY_EN
                            r_state <= PAR;
`else
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud - CW'(1);
                    end
                end
`ifdef LED_UART_PARITY_EN
                PAR: begin
                    if (r_baud == '0) begin
                        r_baud  <= BAUD_RELOAD;
                        r_state <= STOP;
                    end else begin
                        r_baud <= r_baud - CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (r_baud == '0) begin
                        if (r_char_idx == 4'd9) begin
                            r_state <= IDLE;
                        end else begin
                            r_char_idx <= r_char_idx + 4'd1;
                            r_state    <= LOAD;
                        end
                    end else begin
                        r_baud <= r_baud - CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign txd     = r_txd;
    assign busy    = r_busy;
    assign ovf_cnt = r_ovf;

endmodule

// File: tb/tb_led_uart_tx.sv
// tb_led_uart_tx
//   Directed bench for led_uart_tx at CLKS_PER_BIT=4, FIFO_AW=3. A UART
//   receiver decodes txd into a byte queue; timing tables pin txd/busy on
//   exact cycles relative to the edge after which value was driven.
module tb_led_uart_tx;

    localparam int C = 4;
`ifdef LED_UART_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int NBITS = 10 + PAR_EN;
    localparam int FRAME = NBITS * C;
    localparam int CHARC = FRAME + 1;
    localparam int WORD  = 10 * CHARC;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic [31:0] value = '0;
    logic        txd;
    logic        busy;
    logic [7:0]  ovf_cnt;

    led_uart_tx #(
        .CLKS_PER_BIT(C),
        .FIFO_AW(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .value(value),
        .txd(txd),
        .busy(busy),
        .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cur   = 0;

    typedef struct {
        int   off;
        logic txd;
        logic busy;
    } vec_t;
    vec_t tv[$];

    logic [7:0] rx_q[$];
    logic       rx_pq[$];
    logic       rx_sq[$];
    logic [7:0] exp_q[$];

    // Receiver: samples mid-bit on falling clock edges
    bit         rx_act = 1'b0;
    int         rx_cnt = 0;
    int         rx_n   = 0;
    logic [7:0] rx_sh  = '0;
    logic       rx_par = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                rx_act = 1'b0;
            end else if (!rx_act) begin
                if (txd === 1'b0) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % C == C / 2) begin
                    rx_n = rx_cnt / C;
                    if (rx_n == 0) begin
                        if (txd !== 1'b0) rx_act = 1'b0;
                    end else if (rx_n <= 8) begin
                        rx_sh[rx_n-1] = txd;
                    end else if (rx_n == 9 && PAR_EN == 1) begin
                        rx_par = txd;
                    end else begin
                        rx_q.push_back(rx_sh);
                        rx_pq.push_back(rx_par);
                        rx_sq.push_back(txd);
                        rx_act = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input int to);
        while (cur < to) begin
            tick();
            cur++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_rx(input string name, input int base);
        int got = rx_q.size() - base;
        int badstop = 0;
        chk({name, "_count"}, got, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got; i++) begin
            chk($sformatf("%s_byte%0d", name, i), rx_q[base+i], exp_q[i]);
            if (rx_sq[base+i] !== 1'b1) badstop++;
        end
        chk({name, "_stopbits"}, badstop, 0);
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tv.size(); i++) begin
            adv(tv[i].off);
            chk($sformatf("%s_txd@%0d", name, tv[i].off), txd, tv[i].txd);
            chk($sformatf("%s_busy@%0d", name, tv[i].off), busy, tv[i].busy);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 8; i++) exp_q.push_back(hexc(w[31-4*i -: 4]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    int base;
    int bad;

    initial begin
        // Reset state
        rst   = 1'b0;
        value = '0;
        repeat (3) tick();
        chk("reset_txd", txd, 1);
        chk("reset_busy", busy, 0);
        chk("reset_ovf", ovf_cnt, 0);
        rst = 1'b1;

        // Constant zero: nothing captured
        base = rx_q.size();
        bad  = 0;
        repeat (2000) begin
            tick();
            if (txd !== 1'b1 || busy !== 1'b0 || ovf_cnt !== 8'd0) bad++;
        end
        chk("idle_bad_cycles", bad, 0);
        chk("idle_no_bytes", rx_q.size() - base, 0);

        // Single word 0xA5 with exact bit timing
        base  = rx_q.size();
        value = 32'h0000_00A5;
        cur   = 0;
        tv.delete();
        tv.push_back('{2, 1'b1, 1'b0});
        tv.push_back('{3, 1'b1, 1'b1});
        tv.push_back('{4, 1'b1, 1'b1});
        tv.push_back('{5, 1'b0, 1'b1});
        tv.push_back('{8, 1'b0, 1'b1});
        tv.push_back('{9, 1'b0, 1'b1});
        tv.push_back('{24, 1'b0, 1'b1});
        tv.push_back('{25, 1'b1, 1'b1});
        tv.push_back('{32, 1'b1, 1'b1});
        tv.push_back('{33, 1'b0, 1'b1});
        tv.push_back('{40, 1'b0, 1'b1});
        tv.push_back('{41, (PAR_EN == 1) ? 1'b0 : 1'b1, 1'b1});
        tv.push_back('{4 + FRAME, 1'b1, 1'b1});
        tv.push_back('{5 + FRAME, 1'b1, 1'b1});
        tv.push_back('{6 + FRAME, 1'b0, 1'b1});
        tv.push_back('{3 + WORD, 1'b1, 1'b1});
        tv.push_back('{4 + WORD, 1'b1, 1'b0});
        run_table("a5");
        adv(WORD + 30);
        exp_q = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h41, 8'h35, 8'h0D, 8'h0A};
        chk_rx("a5_rx", base);
        chk("a5_ovf", ovf_cnt, 0);
        chk("a5_busy_end", busy, 0);

        // Reset in the middle of DATA of char 3
        base  = rx_q.size();
        value = 32'h1234_5678;
        cur   = 0;
        adv(10 + 3 * CHARC);
        chk("mid_txd_before_rst", txd, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_txd", txd, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovf", ovf_cnt, 0);
        value = '0;
        repeat (3) tick();
        rst = 1'b1;
        exp_q = '{8'h31, 8'h32, 8'h33};
        chk_rx("mid_partial_rx", base);
        repeat (3) tick();
        chk("mid_after_rel_busy", busy, 0);
        base  = rx_q.size();
        value = 32'hDEAD_BEEF;
        cur   = 0;
        adv(WORD + 30);
        exp_q = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        chk_rx("deadbeef_rx", base);

        // Burst of 12 values, then a push coinciding with a pop on a full FIFO
        rst   = 1'b0;
        value = '0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        base = rx_q.size();
        cur  = 0;
        for (int i = 1; i <= 12; i++) begin
            value = i;
            tick();
            cur++;
        end
        adv(14);
        chk("burst_ovf", ovf_cnt, 3);
        chk("burst_busy", busy, 1);
        adv(WORD + 2);
        value = 32'h0000_00D0;
        adv(WORD + 6);
        chk("fullpop_ovf", ovf_cnt, 3);
        adv(3 + 10 * (WORD + 1) + 30);
        exp_q.delete();
        for (int i = 1; i <= 9; i++) push_word(i);
        push_word(32'h0000_00D0);
        chk_rx("burst_rx", base);
        chk("burst_busy_end", busy, 0);
        chk("burst_ovf_end", ovf_cnt, 3);

`ifdef LED_UART_PARITY_EN
        // Even parity on 0x00000007
        base  = rx_q.size();
        value = 32'h0000_0007;
        cur   = 0;
        tv.delete();
        tv.push_back('{41, 1'b0, 1'b1});
        tv.push_back('{45, 1'b1, 1'b1});
        tv.push_back('{49, 1'b1, 1'b1});
        tv.push_back('{50, 1'b0, 1'b1});
        tv.push_back('{5 + 7 * CHARC + 35, 1'b0, 1'b1});
        tv.push_back('{5 + 7 * CHARC + 36, 1'b1, 1'b1});
        run_table("par");
        adv(WORD + 30);
        exp_q = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A};
        chk_rx("par_rx", base);
        if (rx_pq.size() >= base + 10) begin
            chk("par_bit_char0", rx_pq[base], 0);
            chk("par_bit_char7", rx_pq[base+7], 1);
            chk("par_bit_cr", rx_pq[base+8], 1);
            chk("par_bit_lf", rx_pq[base+9], 0);
        end else begin
            chk("par_rx_frames", rx_pq.size() - base, 10);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
